// File: rtl/juntar_num.sv
// juntar_num: sequential 4-digit BCD to binary converter (acc = acc*10 + digit, MSB digit first).
// Optional digit validation: define JUNTAR_NUM_DIGIT_CHECK_EN to flag digits > 9 on err.
module juntar_num #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   mill,
    input  logic [3:0]   cen,
    input  logic [3:0]   dec,
    input  logic [3:0]   uni,
    output logic [W-1:0] num,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t       state;
    logic [W-1:0] acc;
    logic [W-1:0] acc_next;
    logic [1:0]   cnt;
    logic [3:0]   d_mill, d_cen, d_dec, d_uni;
    logic [3:0]   digit;
    logic         accept;

    // The DONE cycle doubles as an idle cycle, so a held start restarts every 5 clocks.
    assign accept = start && (state == IDLE || state == DONE);

    always_comb begin
        digit = d_uni;
        case (cnt)
            2'd0:    digit = d_mill;
            2'd1:    digit = d_cen;
            2'd2:    digit = d_dec;
            default: digit = d_uni;
        endcase
    end

    // x*10 as x*8 + x*2, wrapping modulo 2^W.
    assign acc_next = (acc << 3) + (acc << 1) + W'(digit);

`ifdef JUNTAR_NUM_DIGIT_CHECK_EN
    logic bad;
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            num    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            cnt    <= 2'd0;
            d_mill <= 4'd0;
            d_cen  <= 4'd0;
            d_dec  <= 4'd0;
            d_uni  <= 4'd0;
`ifdef JUNTAR_NUM_DIGIT_CHECK_EN
            bad    <= 1'b0;
            err_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        d_mill <= mill;
                        d_cen  <= cen;
                        d_dec  <= dec;
                        d_uni  <= uni;
                        acc    <= '0;
                        cnt    <= 2'd0;
                        busy   <= 1'b1;
                        state  <= ACC;
`ifdef JUNTAR_NUM_DIGIT_CHECK_EN
                        err_q  <= 1'b0;
                        bad    <= (mill > 4'd9) || (cen > 4'd9) || (dec > 4'd9) || (uni > 4'd9);
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                ACC: begin
`ifdef JUNTAR_NUM_DIGIT_CHECK_EN
                    if (bad) begin
                        // Invalid capture: report immediately, keep the previous result.
                        err_q <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else
`endif
                    begin
                        acc <= acc_next;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            num   <= acc_next;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_juntar_num.sv
// Self-checking bench for juntar_num: table of directed conversions plus
// hand-written sequences for held start, reset mid-conversion and rst/start collision.
module tb_juntar_num;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   mill, cen, dec, uni;
    logic [W-1:0] num;
    logic         busy, done, err;

    int errors = 0;
    int checks = 0;

    juntar_num #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mill(mill), .cen(cen), .dec(dec), .uni(uni),
        .num(num), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   m, c, d, u;
        logic [W-1:0] exp_num;
        logic         invalid;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] m, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] u);
        mill = m; cen = c; dec = d; uni = u;
    endtask

    // One conversion with start pulsed for one cycle; checks busy length, done
    // position, single done pulse and the result. Returns on the negedge after done.
    task automatic run_conv(input vec_t v, input logic [W-1:0] prev_num, input string name);
        int busy_cnt = 0;
        int done_at  = 0;
        logic [W-1:0] exp_num;
        logic exp_err;
        int exp_done_at;
        int exp_busy;
        exp_num = v.exp_num; exp_err = 1'b0; exp_done_at = 5; exp_busy = 4;
`ifdef JUNTAR_NUM_DIGIT_CHECK_EN
        if (v.invalid) begin
            exp_num = prev_num; exp_err = 1'b1; exp_done_at = 2; exp_busy = 1;
        end
`endif
        @(negedge clk);
        set_digits(v.m, v.c, v.d, v.u);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_digits(4'd3, 4'd3, 4'd3, 4'd3);
        for (int i = 1; i <= 20; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
            if (i < 4) check({name, " num_held"}, 32'(num), 32'(prev_num));
            @(negedge clk);
        end
        check({name, " done_at"}, done_at, exp_done_at);
        check({name, " busy_cycles"}, busy_cnt, exp_busy);
        check({name, " num"}, 32'(num), 32'(exp_num));
        check({name, " err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({name, " done_once"}, 32'(done), 0);
    endtask

    vec_t vecs[6];
    logic [W-1:0] last;

    initial begin
        rst = 1'b1; start = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        vecs[0] = '{m:4'd9, c:4'd8, d:4'd0, u:4'd1, exp_num:14'd9801,  invalid:1'b0};
        vecs[1] = '{m:4'd7, c:4'd4, d:4'd5, u:4'd6, exp_num:14'd7456,  invalid:1'b0};
        vecs[2] = '{m:4'd0, c:4'd0, d:4'd0, u:4'd0, exp_num:14'd0,     invalid:1'b0};
        vecs[3] = '{m:4'd9, c:4'd9, d:4'd9, u:4'd9, exp_num:14'h270F,  invalid:1'b0};
        vecs[4] = '{m:4'd1, c:4'd0, d:4'd0, u:4'd0, exp_num:14'd1000,  invalid:1'b0};
        vecs[5] = '{m:4'd9, c:4'hA, d:4'd0, u:4'd0, exp_num:14'd10000, invalid:1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset num", 32'(num), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset err", 32'(err), 0);
        repeat (2) @(negedge clk);
        check("idle busy", 32'(busy), 0);

        last = '0;
        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i], last, $sformatf("vec%0d", i));
            last = num;
        end

        // Start held high: conversions accepted every 5 cycles, mid-busy digit changes ignored.
        @(negedge clk);
        set_digits(4'd9, 4'd9, 4'd9, 4'd9);
        start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("held done@%0d", i), 32'(done), 32'(i == 5 || i == 10));
            check($sformatf("held busy@%0d", i), 32'(busy), 32'(i != 5 && i != 10));
            if (i == 1) set_digits(4'd1, 4'd2, 4'd3, 4'd4);
            if (i == 5) check("held num1", 32'(num), 9999);
            if (i == 6) set_digits(4'd0, 4'd0, 4'd0, 4'd7);
            if (i == 10) begin
                check("held num2", 32'(num), 1234);
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("held stop busy", 32'(busy), 0);

        // Reset during the second ACC cycle of 1,2,3,4 discards the conversion.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst num", 32'(num), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rst no_done@%0d", i), 32'(done), 0);
        end
        run_conv('{m:4'd0, c:4'd0, d:4'd1, u:4'd0, exp_num:14'd10, invalid:1'b0}, 14'd0, "after_rst");

        // rst and start on the same edge: rst wins.
        set_digits(4'd5, 4'd5, 4'd5, 4'd5);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", 32'(busy), 0);
        check("rst+start num", 32'(num), 0);
        repeat (5) @(negedge clk);
        check("rst+start no_conv", 32'(num), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
